// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running pixel/line counters with registered
// sync, blanking and frame/line strobes, plus an optional delay line for the syncs.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int SYNC_DLY  = 1
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       hs_d,
  output logic       vs_d,
  output logic       blank_d,
  output logic       frame_start,
  output logic       line_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0] h_cnt, v_cnt;
  logic [9:0] h_next, v_next;

  always_comb begin
    h_next = h_cnt + 10'd1;
    v_next = v_cnt;
    if (h_cnt == H_LAST) begin
      h_next = '0;
      v_next = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end
  end

  // Counters park on the last position so the first edge after reset lands on (0,0);
  // every decoded output is computed from the next counts so it lines up with DrawX/DrawY.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      h_cnt       <= H_LAST;
      v_cnt       <= V_LAST;
      DrawX       <= '0;
      DrawY       <= '0;
      blank       <= 1'b0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      h_cnt       <= h_next;
      v_cnt       <= v_next;
      DrawX       <= h_next;
      DrawY       <= v_next;
      blank       <= (h_next < H_VIS_END) && (v_next < V_VIS_END);
      hs          <= !((h_next >= H_SYNC_BEG) && (h_next < H_SYNC_END));
      vs          <= !((v_next >= V_SYNC_BEG) && (v_next < V_SYNC_END));
      line_start  <= (h_next == 10'd0);
      frame_start <= (h_next == 10'd0) && (v_next == 10'd0);
      if (frame_start)
        frame_count <= frame_count + 8'd1;
    end
  end

  generate
    if (SYNC_DLY == 0) begin : g_nodly
      assign hs_d    = hs;
      assign vs_d    = vs;
      assign blank_d = blank;
    end else begin : g_dly
      logic [SYNC_DLY-1:0] hs_pipe, vs_pipe, blank_pipe;

      // Bit 0 takes the newest sample; the top bit is SYNC_DLY clocks old.
      always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
          hs_pipe    <= '1;
          vs_pipe    <= '1;
          blank_pipe <= '0;
        end else begin
          hs_pipe    <= SYNC_DLY'({hs_pipe, hs});
          vs_pipe    <= SYNC_DLY'({vs_pipe, vs});
          blank_pipe <= SYNC_DLY'({blank_pipe, blank});
        end
      end

      assign hs_d    = hs_pipe[SYNC_DLY-1];
      assign vs_d    = vs_pipe[SYNC_DLY-1];
      assign blank_d = blank_pipe[SYNC_DLY-1];
    end
  endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: several parameterisations checked cycle by cycle against
// an arithmetic raster model driven by the number of edges since reset release.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  localparam int D_HV = 640, D_HF = 16, D_HS = 96, D_HB = 48;
  localparam int D_VV = 480, D_VF = 10, D_VS = 2,  D_VB = 33;
  localparam int M_HV = 16,  M_HF = 2,  M_HS = 4,  M_HB = 2;
  localparam int M_VV = 8,   M_VF = 2,  M_VS = 2,  M_VB = 2;
  localparam int M_FRAME = (M_HV + M_HF + M_HS + M_HB) * (M_VV + M_VF + M_VS + M_VB);
  localparam int S_HV = 4, S_HF = 1, S_HS = 1, S_HB = 1;
  localparam int S_VV = 2, S_VF = 1, S_VS = 1, S_VB = 1;

  logic vga_clk = 1'b0;
  logic reset   = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   t        = 0;

  always #5 vga_clk = ~vga_clk;

  logic [9:0] d_x, d_y, t2_x, t2_y, z_x, z_y, m_x, m_y, s_x, s_y;
  logic       d_bl, d_hs, d_vs, d_hsd, d_vsd, d_bd, d_fs, d_ls;
  logic       t2_bl, t2_hs, t2_vs, t2_hsd, t2_vsd, t2_bd, t2_fs, t2_ls;
  logic       z_bl, z_hs, z_vs, z_hsd, z_vsd, z_bd, z_fs, z_ls;
  logic       m_bl, m_hs, m_vs, m_hsd, m_vsd, m_bd, m_fs, m_ls;
  logic       s_bl, s_hs, s_vs, s_hsd, s_vsd, s_bd, s_fs, s_ls;
  logic [7:0] d_fc, t2_fc, z_fc, m_fc, s_fc;

  vga_timing_gen u_def (
    .vga_clk(vga_clk), .reset(reset), .DrawX(d_x), .DrawY(d_y), .blank(d_bl),
    .hs(d_hs), .vs(d_vs), .hs_d(d_hsd), .vs_d(d_vsd), .blank_d(d_bd),
    .frame_start(d_fs), .line_start(d_ls), .frame_count(d_fc));

  vga_timing_gen #(.SYNC_DLY(2)) u_dly2 (
    .vga_clk(vga_clk), .reset(reset), .DrawX(t2_x), .DrawY(t2_y), .blank(t2_bl),
    .hs(t2_hs), .vs(t2_vs), .hs_d(t2_hsd), .vs_d(t2_vsd), .blank_d(t2_bd),
    .frame_start(t2_fs), .line_start(t2_ls), .frame_count(t2_fc));

  vga_timing_gen #(.SYNC_DLY(0)) u_dly0 (
    .vga_clk(vga_clk), .reset(reset), .DrawX(z_x), .DrawY(z_y), .blank(z_bl),
    .hs(z_hs), .vs(z_vs), .hs_d(z_hsd), .vs_d(z_vsd), .blank_d(z_bd),
    .frame_start(z_fs), .line_start(z_ls), .frame_count(z_fc));

  vga_timing_gen #(.H_VISIBLE(M_HV), .H_FP(M_HF), .H_SYNC(M_HS), .H_BP(M_HB),
                   .V_VISIBLE(M_VV), .V_FP(M_VF), .V_SYNC(M_VS), .V_BP(M_VB)) u_mid (
    .vga_clk(vga_clk), .reset(reset), .DrawX(m_x), .DrawY(m_y), .blank(m_bl),
    .hs(m_hs), .vs(m_vs), .hs_d(m_hsd), .vs_d(m_vsd), .blank_d(m_bd),
    .frame_start(m_fs), .line_start(m_ls), .frame_count(m_fc));

  vga_timing_gen #(.H_VISIBLE(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
                   .V_VISIBLE(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)) u_small (
    .vga_clk(vga_clk), .reset(reset), .DrawX(s_x), .DrawY(s_y), .blank(s_bl),
    .hs(s_hs), .vs(s_vs), .hs_d(s_hsd), .vs_d(s_vsd), .blank_d(s_bd),
    .frame_start(s_fs), .line_start(s_ls), .frame_count(s_fc));

  // Model: edge tt (1 = first edge after release) shows raster position tt-1 of the
  // repeating frame. Packed as {x[32:23], y[22:13], blank[12], hs[11], vs[10],
  // line_start[9], frame_start[8], frame_count[7:0]}.
  function automatic logic [32:0] exp_main(input int tt,
      input int hv, input int hf, input int hsw, input int hb,
      input int vv, input int vf, input int vsw, input int vb);
    int ht, vt, pos, x, y, fc;
    logic bl, h, v;
    if (tt <= 0) return {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    ht  = hv + hf + hsw + hb;
    vt  = vv + vf + vsw + vb;
    pos = (tt - 1) % (ht * vt);
    x   = pos % ht;
    y   = pos / ht;
    bl  = (x < hv) && (y < vv);
    h   = !((x >= hv + hf) && (x < hv + hf + hsw));
    v   = !((y >= vv + vf) && (y < vv + vf + vsw));
    fc  = (tt <= 1) ? 0 : (((tt - 2) / (ht * vt)) + 1) % 256;
    return {10'(x), 10'(y), bl, h, v, (x == 0), (x == 0 && y == 0), 8'(fc)};
  endfunction

  // Delayed {hs, vs, blank}: the undelayed value dly edges earlier, reset value before that.
  function automatic logic [2:0] exp_dly(input int tt, input int dly);
    logic [32:0] e;
    if (tt - dly <= 0) return 3'b110;
    e = exp_main(tt - dly, D_HV, D_HF, D_HS, D_HB, D_VV, D_VF, D_VS, D_VB);
    return {e[11], e[10], e[12]};
  endfunction

  task automatic step();
    @(posedge vga_clk);
    #1;
    if (!reset) t++;
  endtask

  task automatic test_reset();
    logic [32:0] rv;
    repeat (3) step();
    rv = exp_main(0, D_HV, D_HF, D_HS, D_HB, D_VV, D_VF, D_VS, D_VB);
    checks++;
    if ({d_x, d_y, d_bl, d_hs, d_vs, d_ls, d_fs, d_fc} !== rv) begin
      failures++;
      $display("[TB] FAIL reset_main got=%h exp=%h", {d_x, d_y, d_bl, d_hs, d_vs, d_ls, d_fs, d_fc}, rv);
    end
    checks++;
    if ({d_hsd, d_vsd, d_bd} !== 3'b110) begin
      failures++;
      $display("[TB] FAIL reset_dly got=%b exp=110", {d_hsd, d_vsd, d_bd});
    end
    reset = 1'b0;
    t     = 0;
  endtask

  task automatic test_first_edges();
    step();
    checks++;
    if ({d_x, d_y, d_bl, d_hs, d_vs, d_ls, d_fs, d_fc} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0}) begin
      failures++;
      $display("[TB] FAIL first_edge got=%h exp=%h", {d_x, d_y, d_bl, d_hs, d_vs, d_ls, d_fs, d_fc},
               {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0});
    end
    step();
    checks++;
    if ({d_x, d_fs, d_ls, d_fc} !== {10'd1, 1'b0, 1'b0, 8'd1}) begin
      failures++;
      $display("[TB] FAIL second_edge got x=%0d fs=%b ls=%b fc=%0d exp x=1 fs=0 ls=0 fc=1", d_x, d_fs, d_ls, d_fc);
    end
  endtask

  task automatic test_sync_delay();
    logic [32:0] e;
    for (int i = 0; i < 300 + int'($urandom_range(0, 200)); i++) begin
      step();
      e = exp_main(t, D_HV, D_HF, D_HS, D_HB, D_VV, D_VF, D_VS, D_VB);
      checks++;
      if ({t2_x, t2_y, t2_bl, t2_hs, t2_vs, t2_ls, t2_fs, t2_fc} !== e ||
          {z_x, z_y, z_bl, z_hs, z_vs, z_ls, z_fs, z_fc} !== e) begin
        failures++;
        $display("[TB] FAIL dly_main t=%0d got2=%h got0=%h exp=%h", t,
                 {t2_x, t2_y, t2_bl, t2_hs, t2_vs, t2_ls, t2_fs, t2_fc},
                 {z_x, z_y, z_bl, z_hs, z_vs, z_ls, z_fs, z_fc}, e);
      end
      checks++;
      if ({d_hsd, d_vsd, d_bd} !== exp_dly(t, 1)) begin
        failures++;
        $display("[TB] FAIL dly1 t=%0d got=%b exp=%b", t, {d_hsd, d_vsd, d_bd}, exp_dly(t, 1));
      end
      checks++;
      if ({t2_hsd, t2_vsd, t2_bd} !== exp_dly(t, 2)) begin
        failures++;
        $display("[TB] FAIL dly2 t=%0d got=%b exp=%b", t, {t2_hsd, t2_vsd, t2_bd}, exp_dly(t, 2));
      end
      checks++;
      if ({z_hsd, z_vsd, z_bd} !== exp_dly(t, 0)) begin
        failures++;
        $display("[TB] FAIL dly0 t=%0d got=%b exp=%b", t, {z_hsd, z_vsd, z_bd}, exp_dly(t, 0));
      end
    end
  endtask

  task automatic test_line_default();
    logic [32:0] e;
    int hs_low = 0;
    int bl_low = 0;
    while (t < 2 * 800 + 3) begin
      step();
      e = exp_main(t, D_HV, D_HF, D_HS, D_HB, D_VV, D_VF, D_VS, D_VB);
      checks++;
      if ({d_x, d_y, d_bl, d_hs, d_vs, d_ls, d_fs, d_fc} !== e) begin
        failures++;
        $display("[TB] FAIL line_main t=%0d got=%h exp=%h", t, {d_x, d_y, d_bl, d_hs, d_vs, d_ls, d_fs, d_fc}, e);
      end
      if (d_y == 10'd1 && d_hs == 1'b0) hs_low++;
      if (d_y == 10'd1 && d_bl == 1'b0) bl_low++;
    end
    checks++;
    if (hs_low != 96) begin
      failures++;
      $display("[TB] FAIL hs_width got=%0d exp=96", hs_low);
    end
    checks++;
    if (bl_low != 160) begin
      failures++;
      $display("[TB] FAIL hblank_width got=%0d exp=160", bl_low);
    end
  endtask

  task automatic test_frame_mid();
    logic [32:0] e;
    int n = 0;
    int vs_low = 0;
    int extra_fs = 0;
    while (m_fs !== 1'b1 && n < 2 * M_FRAME) begin
      step();
      n++;
    end
    checks++;
    if (m_fs !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid_fs_timeout got=%b exp=1", m_fs);
    end
    for (int i = 0; i < M_FRAME; i++) begin
      if (m_vs == 1'b0) vs_low++;
      step();
      e = exp_main(t, M_HV, M_HF, M_HS, M_HB, M_VV, M_VF, M_VS, M_VB);
      checks++;
      if ({m_x, m_y, m_bl, m_hs, m_vs, m_ls, m_fs, m_fc} !== e) begin
        failures++;
        $display("[TB] FAIL mid_main t=%0d got=%h exp=%h", t, {m_x, m_y, m_bl, m_hs, m_vs, m_ls, m_fs, m_fc}, e);
      end
      if (i < M_FRAME - 1 && m_fs) extra_fs++;
    end
    checks++;
    if (m_fs !== 1'b1 || extra_fs != 0) begin
      failures++;
      $display("[TB] FAIL mid_period got fs=%b extra=%0d exp fs=1 extra=0", m_fs, extra_fs);
    end
    checks++;
    if (vs_low != M_VS * (M_HV + M_HF + M_HS + M_HB)) begin
      failures++;
      $display("[TB] FAIL mid_vs_width got=%0d exp=%0d", vs_low, M_VS * (M_HV + M_HF + M_HS + M_HB));
    end
  endtask

  task automatic test_async_reset();
    logic [32:0] rv;
    repeat ($urandom_range(50, 400)) step();
    #($urandom_range(1, 2));
    reset = 1'b1;
    #1;
    rv = exp_main(0, D_HV, D_HF, D_HS, D_HB, D_VV, D_VF, D_VS, D_VB);
    checks++;
    if ({d_x, d_y, d_bl, d_hs, d_vs, d_ls, d_fs, d_fc} !== rv ||
        {t2_x, t2_y, t2_bl, t2_hs, t2_vs, t2_ls, t2_fs, t2_fc} !== rv ||
        {z_x, z_y, z_bl, z_hs, z_vs, z_ls, z_fs, z_fc} !== rv ||
        {m_x, m_y, m_bl, m_hs, m_vs, m_ls, m_fs, m_fc} !== rv ||
        {s_x, s_y, s_bl, s_hs, s_vs, s_ls, s_fs, s_fc} !== rv) begin
      failures++;
      $display("[TB] FAIL async_main got=%h/%h/%h/%h/%h exp=%h",
               {d_x, d_y, d_bl, d_hs, d_vs, d_ls, d_fs, d_fc}, {t2_x, t2_y, t2_bl, t2_hs, t2_vs, t2_ls, t2_fs, t2_fc},
               {z_x, z_y, z_bl, z_hs, z_vs, z_ls, z_fs, z_fc}, {m_x, m_y, m_bl, m_hs, m_vs, m_ls, m_fs, m_fc},
               {s_x, s_y, s_bl, s_hs, s_vs, s_ls, s_fs, s_fc}, rv);
    end
    checks++;
    if ({d_hsd, d_vsd, d_bd, t2_hsd, t2_vsd, t2_bd, z_hsd, z_vsd, z_bd,
         m_hsd, m_vsd, m_bd, s_hsd, s_vsd, s_bd} !== {5{3'b110}}) begin
      failures++;
      $display("[TB] FAIL async_dly got=%b exp=%b", {d_hsd, d_vsd, d_bd, t2_hsd, t2_vsd, t2_bd, z_hsd, z_vsd, z_bd,
               m_hsd, m_vsd, m_bd, s_hsd, s_vsd, s_bd}, {5{3'b110}});
    end
    repeat (2) step();
    checks++;
    if ({d_x, d_y, d_fc, d_fs} !== {10'd0, 10'd0, 8'd0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL async_hold got x=%0d y=%0d fc=%0d fs=%b exp 0 0 0 0", d_x, d_y, d_fc, d_fs);
    end
    reset = 1'b0;
    t     = 0;
  endtask

  task automatic test_frame_count_wrap();
    logic [32:0] e;
    while (t < 2 + 256 * 35 + 5) begin
      step();
      e = exp_main(t, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB);
      checks++;
      if ({s_x, s_y, s_bl, s_hs, s_vs, s_ls, s_fs, s_fc} !== e) begin
        failures++;
        $display("[TB] FAIL small_main t=%0d got=%h exp=%h", t, {s_x, s_y, s_bl, s_hs, s_vs, s_ls, s_fs, s_fc}, e);
      end
      if (t == 2 + 254 * 35 || t == 2 + 255 * 35 || t == 2 + 256 * 35) begin
        checks++;
        if (s_fc !== ((t == 2 + 254 * 35) ? 8'd255 : (t == 2 + 255 * 35) ? 8'd0 : 8'd1)) begin
          failures++;
          $display("[TB] FAIL fc_wrap t=%0d got=%0d", t, s_fc);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_edges();
    test_sync_delay();
    test_line_default();
    test_frame_mid();
    test_async_reset();
    test_first_edges();
    test_frame_count_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_VISIBLE, 640, active pixels per line.
REQ-002 SHALL have parameter H_FP, 16, horizontal front porch in clocks.
REQ-003 SHALL have parameter H_SYNC, 96, horizontal sync width in clocks.
REQ-004 SHALL have parameter H_BP, 48, horizontal back porch in clocks.
REQ-005 SHALL have parameter V_VISIBLE, 480, active lines per frame.
REQ-006 SHALL have parameter V_FP, 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, 2, vertical sync width in lines.
REQ-008 SHALL have parameter V_BP, 33, vertical back porch in lines.
REQ-009 SHALL have parameter SYNC_DLY, 1, pipeline delay (0..4) applied to hs_d/vs_d/blank_d to match renderer latency.
REQ-010 SHALL have port vga_clk  input  1  pixel clock; the block's only clock.
REQ-011 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-012 SHALL have port DrawX  output  10  current horizontal count, 0..H_TOTAL-1.
REQ-013 SHALL have port DrawY  output  10  current vertical count, 0..V_TOTAL-1.
REQ-014 SHALL have port blank  output  1  1 = visible pixel (display enabled), 0 = blanking.
REQ-015 SHALL have port hs / vs  output  1 each  horizontal / vertical sync, active low.
REQ-016 SHALL have port hs_d / vs_d / blank_d  output  1 each  hs/vs/blank delayed by SYNC_DLY clocks.
REQ-017 SHALL have port frame_start / line_start  output  1 each  single-cycle pulses.
REQ-018 SHALL have port frame_count  output  8  frames started since reset, modulo 256.

Function
REQ-019 H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL likewise (default 525); all count compares SHALL be unsigned and 10-bit.
REQ-020 DrawX SHALL increment by 1 each vga_clk rising edge; from H_TOTAL-1 it SHALL wrap to 0.
REQ-021 DrawY SHALL increment only on the edge where DrawX wraps; from V_TOTAL-1 it SHALL wrap to 0 on that same edge (simultaneous wrap of both).
REQ-022 All outputs SHALL be registered; blank/hs/vs/frame_start/line_start SHALL describe the DrawX/DrawY values presented in the same cycle (decoded from next-state counts, glitch-free).
REQ-023 blank SHALL be 1 iff DrawX < H_VISIBLE and DrawY < V_VISIBLE.
REQ-024 hs SHALL be 0 iff H_VISIBLE+H_FP <= DrawX < H_VISIBLE+H_FP+H_SYNC (default 656..751).
REQ-025 vs SHALL be 0 iff V_VISIBLE+V_FP <= DrawY < V_VISIBLE+V_FP+V_SYNC (default 490..491), for the whole of each such line.
REQ-026 line_start SHALL be 1 iff DrawX = 0; frame_start SHALL be 1 iff DrawX = 0 and DrawY = 0.
REQ-027 frame_count SHALL increment by 1 on each rising edge at which frame_start is 1, wrapping 255 -> 0.
REQ-028 hs_d/vs_d/blank_d SHALL be a SYNC_DLY-stage shift register of hs/vs/blank; with SYNC_DLY = 0 they SHALL equal hs/vs/blank combinationally.
REQ-029 Internal counters SHALL reset to (H_TOTAL-1, V_TOTAL-1) so the first edge after reset release presents DrawX=0, DrawY=0.

Reset
REQ-030 While reset = 1, outputs SHALL immediately (no clock needed) be: DrawX=0, DrawY=0, blank=0, hs=1, vs=1, hs_d=1, vs_d=1, blank_d=0, frame_start=0, line_start=0, frame_count=0.
REQ-031 Reset asserted mid-frame SHALL abandon the frame; after release, timing SHALL restart exactly as after power-up reset.

Verification
REQ-032 Reset release -> first edge: DrawX=0, DrawY=0, blank=1, hs=1, vs=1, frame_start=1, line_start=1; next edge: DrawX=1, frame_start=0, frame_count=1.
REQ-033 Defaults, one line -> hs=0 for exactly 96 cycles (DrawX 656..751), blank=0 for DrawX 640..799, DrawX 799 -> 0 with DrawY incremented.
REQ-034 Defaults, full frame -> vs=0 for exactly 1600 cycles (DrawY 490..491), (799,524) -> (0,0), frame_start period 420000 cycles.
REQ-035 SYNC_DLY=2 -> hs_d/vs_d/blank_d equal hs/vs/blank delayed exactly 2 cycles; SYNC_DLY=0 -> identical to undelayed.
REQ-036 Async reset at DrawX=300, DrawY=200 between edges -> all outputs to REQ-030 values before the next edge; restart per REQ-032.
REQ-037 Small-parameter build (H 4/1/1/1, V 2/1/1/1) run 257 frames -> frame_count reads 255 then 0 then 1; wrap behaviour per REQ-021.
